ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_rr_pick2.sv | 12 +
 rtl/ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths, FSM
// encoding and a helper mapping a port index to its lock state.
package ram_arb_pkg;

    localparam int AW_DEFAULT = 7;
    localparam int DW_DEFAULT = 32;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t lock_state(input logic port);
        return port ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the port
// selected by rr. Grant is one-hot or zero.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       rr,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | ~rr);
    assign grant[1] = valid[1] & (~valid[0] |  rr);

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with combinational
// read data; supports short bus locks bounded by LOCK_MAX cycles.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic          req0_lock,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic          req1_lock,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_w,
    output logic          ram_r,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    logic [1:0]    valid_vec;
    logic [1:0]    we_vec;
    logic [1:0]    lock_vec;
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];

    assign valid_vec    = {req1_valid, req0_valid};
    assign we_vec       = {req1_we, req0_we};
    assign lock_vec     = {req1_lock, req0_lock};
    assign addr_vec[0]  = req0_addr;
    assign addr_vec[1]  = req1_addr;
    assign wdata_vec[0] = req0_wdata;
    assign wdata_vec[1] = req1_wdata;

    arb_state_t       state_reg, state_next;
    logic             rr_reg, rr_next;
    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;

    logic [1:0] pick_grant;
    logic [1:0] ready_vec;
    logic       xfer_port;
    logic       lock_port;

    rr_pick2 u_pick (
        .valid (valid_vec),
        .rr    (rr_reg),
        .grant (pick_grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_reg       <= 1'b0;
            lock_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_reg       <= rr_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // Next-state logic; a ready implies a transfer since ready needs valid
    assign xfer_port = ready_vec[1];
    assign lock_port = (state_reg == ST_LOCK1);

    always_comb begin
        state_next    = state_reg;
        rr_next       = rr_reg;
        lock_cnt_next = lock_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|ready_vec) begin
                    if (lock_vec[xfer_port]) begin
                        state_next    = lock_state(xfer_port);
                        lock_cnt_next = '0;
                    end else begin
                        rr_next = ~xfer_port;
                    end
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                lock_cnt_next = lock_cnt_reg + CNT_W'(1);
                // Forced release goes straight to IDLE even if lock is still asserted
                if ((lock_cnt_reg == LOCK_LAST) ||
                    (ready_vec[lock_port] && !lock_vec[lock_port])) begin
                    state_next    = ST_IDLE;
                    rr_next       = ~lock_port;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                lock_cnt_next = '0;
            end
        endcase
    end

    // Output logic: readies and RAM strobes, all held low during reset
    always_comb begin
        ready_vec = 2'b00;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_w     = 1'b0;
        ram_r     = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_IDLE:  ready_vec = pick_grant;
                ST_LOCK0: ready_vec = {1'b0, valid_vec[0]};
                ST_LOCK1: ready_vec = {valid_vec[1], 1'b0};
                default:  ready_vec = 2'b00;
            endcase
        end
        if (|ready_vec) begin
            ram_addr  = addr_vec[xfer_port];
            ram_wdata = wdata_vec[xfer_port];
            ram_w     = we_vec[xfer_port];
            ram_r     = ~we_vec[xfer_port];
        end
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    logic          rsp_valid_reg [2];
    logic [DW-1:0] rsp_rdata_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsp_valid_reg[gi] <= 1'b0;
                    rsp_rdata_reg[gi] <= '0;
                end else begin
                    rsp_valid_reg[gi] <= ready_vec[gi] & ~we_vec[gi];
                    if (ready_vec[gi] && !we_vec[gi]) begin
                        rsp_rdata_reg[gi] <= ram_rdata;
                    end
                end
            end
        end
    endgenerate

    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp0_rdata = rsp_rdata_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp1_rdata = rsp_rdata_reg[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: single reads, round robin, writes,
// voluntary and forced lock release, reset during a lock.
module tb_ram_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_we, req0_lock;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_we, req1_lock;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req0_ready, rsp0_valid, req1_ready, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_w, ram_r;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_lock  (req0_lock),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_lock  (req1_lock),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_addr   (ram_addr),
        .ram_w      (ram_w),
        .ram_r      (ram_r),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM model: unwritten words read back as a known address pattern
    logic [DW-1:0] mem [128];
    logic [127:0]  written = '0;

    function automatic logic [31:0] preload(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    assign ram_rdata = written[ram_addr] ? mem[ram_addr] : preload(int'(ram_addr));

    always @(posedge clk) begin
        if (ram_w) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port0(input logic v, input logic we, input logic lk,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set_port1(input logic v, input logic we, input logic lk,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
    endtask

    task automatic idle_inputs();
        set_port0(1'b0, 1'b0, 1'b0, '0, '0);
        set_port1(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_port0(1'b1, 1'b0, 1'b0, 7'h01, '0);
        set_port1(1'b1, 1'b1, 1'b0, 7'h02, 32'h1111_2222);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, ram_w, ram_r} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready_strobe: got %b expected 0000", {req0_ready, req1_ready, ram_w, ram_r});
        end
        checks++;
        if ({ram_addr, ram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_ram_bus: got addr=%h wdata=%h expected 0", ram_addr, ram_wdata);
        end
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b d0=%h d1=%h expected 0", {rsp0_valid, rsp1_valid}, rsp0_rdata, rsp1_rdata);
        end
        $display("txn reset: ready=%b%b ram_w=%b ram_r=%b", req1_ready, req0_ready, ram_w, ram_r);
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_single_read();
        next_cycle();
        set_port0(1'b1, 1'b0, 1'b0, 7'h05, '0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, ram_r, ram_w} !== 4'b1010 || ram_addr !== 7'h05) begin
            errors++;
            $display("FAIL single_read_issue: got rdy0=%b rdy1=%b r=%b w=%b addr=%h expected 1 0 1 0 05",
                     req0_ready, req1_ready, ram_r, ram_w, ram_addr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hA500_0005) begin
            errors++;
            $display("FAIL single_read_rsp: got v=%b d=%h expected 1 a5000005", rsp0_valid, rsp0_rdata);
        end
        checks++;
        if ({ram_r, ram_w} !== 2'b00 || ram_addr !== '0) begin
            errors++;
            $display("FAIL idle_ram_bus: got r=%b w=%b addr=%h expected 0 0 00", ram_r, ram_w, ram_addr);
        end
        $display("txn read p0 addr=05 data=%h", rsp0_rdata);
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0 || rsp0_rdata !== 32'hA500_0005) begin
            errors++;
            $display("FAIL rsp_hold: got v=%b d=%h expected 0 a5000005", rsp0_valid, rsp0_rdata);
        end
    endtask

    task automatic test_round_robin();
        int exp_port;
        logic [AW-1:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_port0(1'b1, 1'b0, 1'b0, 7'(8'h20 + i), '0);
            set_port1(1'b1, 1'b0, 1'b0, 7'(8'h30 + i), '0);
            @(negedge clk);
            exp_port = i % 2;
            exp_addr = (exp_port == 1) ? 7'(8'h30 + i) : 7'(8'h20 + i);
            checks++;
            if (req0_ready !== (exp_port == 0) || req1_ready !== (exp_port == 1) || ram_addr !== exp_addr) begin
                errors++;
                $display("FAIL rr_grant%0d: got rdy=%b%b addr=%h expected port %0d addr=%h",
                         i, req1_ready, req0_ready, ram_addr, exp_port, exp_addr);
            end
            if (i > 0) begin
                checks++;
                if (rsp0_valid !== (exp_port == 1) || rsp1_valid !== (exp_port == 0)) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: got v=%b%b expected port %0d", i, rsp1_valid, rsp0_valid, 1 - exp_port);
                end
            end
            $display("txn rr cycle %0d: grant=%b%b addr=%h", i, req1_ready, req0_ready, ram_addr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hA500_0033) begin
            errors++;
            $display("FAIL rr_last_rsp: got v=%b d=%h expected 1 a5000033", rsp1_valid, rsp1_rdata);
        end
    endtask

    task automatic test_write();
        next_cycle();
        set_port1(1'b1, 1'b1, 1'b0, 7'h7F, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if ({req1_ready, ram_w, ram_r} !== 3'b110 || ram_addr !== 7'h7F || ram_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_issue: got rdy1=%b w=%b r=%b addr=%h wd=%h expected 1 1 0 7f deadbeef",
                     req1_ready, ram_w, ram_r, ram_addr, ram_wdata);
        end
        $display("txn write p1 addr=7f data=deadbeef");
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (ram_w !== 1'b0 || rsp1_valid !== 1'b0 || ram_wdata !== '0) begin
            errors++;
            $display("FAIL write_after: got w=%b rsp1_v=%b wd=%h expected 0 0 0", ram_w, rsp1_valid, ram_wdata);
        end
        next_cycle();
        set_port1(1'b1, 1'b0, 1'b0, 7'h7F, '0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_readback: got v=%b d=%h expected 1 deadbeef", rsp1_valid, rsp1_rdata);
        end
        $display("txn read p1 addr=7f data=%h", rsp1_rdata);
    endtask

    task automatic test_lock_release();
        next_cycle();
        set_port0(1'b1, 1'b0, 1'b1, 7'h10, '0);
        set_port1(1'b1, 1'b0, 1'b0, 7'h11, '0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL lock_enter: got rdy=%b%b expected 01", req1_ready, req0_ready);
        end
        next_cycle();
        set_port0(1'b1, 1'b1, 1'b0, 7'h10, 32'h1234_5678);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready, ram_w} !== 3'b011 || rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hA500_0010) begin
            errors++;
            $display("FAIL lock_write: got rdy=%b%b w=%b rsp0=%b/%h expected 01 1 1/a5000010",
                     req1_ready, req0_ready, ram_w, rsp0_valid, rsp0_rdata);
        end
        next_cycle();
        set_port0(1'b1, 1'b0, 1'b0, 7'h10, '0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_handover: got rdy=%b%b rsp0_v=%b expected 10 0", req1_ready, req0_ready, rsp0_valid);
        end
        next_cycle();
        set_port1(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hA500_0011) begin
            errors++;
            $display("FAIL lock_p1_rsp: got rdy0=%b rsp1=%b/%h expected 1 1/a5000011", req0_ready, rsp1_valid, rsp1_rdata);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lock_readback: got v=%b d=%h expected 1 12345678", rsp0_valid, rsp0_rdata);
        end
        $display("txn lock p0 addr=10 write/read data=%h", rsp0_rdata);
    endtask

    task automatic test_forced_release();
        // cycle 0 enters LOCK0, cycles 1..8 are in LOCK0, cycle 9 belongs to port 1
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            set_port0(1'b1, 1'b0, 1'b1, 7'h01, '0);
            set_port1(i > 0, 1'b0, 1'b0, 7'h02, '0);
            @(negedge clk);
            checks++;
            if (req0_ready !== (i <= 8) || req1_ready !== (i == 9)) begin
                errors++;
                $display("FAIL forced_release%0d: got rdy=%b%b expected %b%b",
                         i, req1_ready, req0_ready, (i == 9), (i <= 8));
            end
            $display("txn lock-hold cycle %0d: grant=%b%b", i, req1_ready, req0_ready);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_lock();
        next_cycle();
        set_port1(1'b1, 1'b0, 1'b1, 7'h22, '0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL lock1_enter: got rdy=%b%b expected 10", req1_ready, req0_ready);
        end
        next_cycle();
        set_port0(1'b1, 1'b0, 1'b0, 7'h03, '0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL lock1_hold: got rdy=%b%b expected 10", req1_ready, req0_ready);
        end
        next_cycle();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'hA500_0022) begin
            errors++;
            $display("FAIL lock1_rsp: got v=%b d=%h expected 1 a5000022", rsp1_valid, rsp1_rdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_r, ram_w} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_lock: got rdy=%b%b rsp_v=%b%b r=%b w=%b expected all 0",
                     req1_ready, req0_ready, rsp1_valid, rsp0_valid, ram_r, ram_w);
        end
        next_cycle();
        rst_n = 1'b1;
        set_port1(1'b1, 1'b0, 1'b0, 7'h22, '0);
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_tie: got rdy=%b%b expected 01", req1_ready, req0_ready);
        end
        $display("txn post-reset tie: grant=%b%b", req1_ready, req0_ready);
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        do_reset();
        test_round_robin();
        test_write();
        test_lock_release();
        test_forced_release();
        test_reset_mid_lock();
        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
